sec_loc_remainder: RTL and testbench

SEC_LOC_REMAINDER -- requirements
Module: sec_loc_remainder

---
 rtl/sec_loc_remainder.sv | 172 +++++++++++++++++
 tb/tb_sec_loc_remainder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sec_loc_remainder.sv
`default_nettype none
// ============================================================================
// Module      : sec_loc_remainder
// Description : Maps a signed single-error location l of an AN-coded word to
//               the remainder that the error leaves modulo A:
//                 l > 0 : out_r = 2^(|l|-1) mod A
//                 l < 0 : out_r = A - (2^(|l|-1) mod A)
//               The power of two is formed by iterating a single modular
//               doubler (no lookup table), one doubling per clock. A request
//               with l = 1 produces its result one edge after acceptance, and
//               in general |l| edges after acceptance.
//               Illegal locations (0, |l| > MAXL, or the most negative LW-bit
//               value) are flagged with out_err = 1 and out_r = 0.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   A     AN-code modulus (odd, > 2)
//   RW    remainder width, A < 2^RW
//   LW    signed location width, MAXL < 2^(LW-1)
//   MAXL  largest legal |l|
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request present
//   in_ready   block accepts a request (IDLE only)
//   in_l       signed location, sampled on the accept edge only
//   out_valid  result held on out_r / out_err
//   out_ready  consumer takes the result
//   out_r      remainder (holds last value outside DONE)
//   out_err    request carried an illegal location
//   busy       a request is in flight (CALC or DONE)
// ============================================================================
module sec_loc_remainder #(
  parameter int A    = 17619,
  parameter int RW   = 15,
  parameter int LW   = 7,
  parameter int MAXL = 43
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] in_l,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_r,
  output logic          out_err,
  output logic          busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [RW:0]   c_a_ext = (RW+1)'(A);
  localparam logic [RW-1:0] c_a     = RW'(A);
  localparam logic [LW-1:0] c_maxl  = LW'(MAXL);
  localparam logic [LW-1:0] c_lmin  = {1'b1, {(LW-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_sign;     // error polarity captured at accept
  logic          r_bad;      // captured location was illegal
  logic [LW-1:0] r_cnt;      // doublings still to perform
  logic [RW-1:0] r_acc;      // running 2^k mod A, always in [1, A-1]
  logic [RW-1:0] r_out_r;
  logic          r_out_err;

  // --------------------------------------------------------------------------
  // Location decode (only meaningful on the accept edge)
  // --------------------------------------------------------------------------
  logic          w_neg;
  logic [LW-1:0] w_mag;
  logic          w_illegal;
  logic          w_accept;

  assign w_neg    = in_l[LW-1];
  // For the most negative value the negation wraps back to itself; that
  // value is rejected explicitly below, so the wrap never reaches r_cnt.
  assign w_mag    = w_neg ? (LW'(0) - in_l) : in_l;
  assign w_illegal = (in_l == '0) || (in_l == c_lmin) || (w_mag > c_maxl);
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // --------------------------------------------------------------------------
  // Modular doubler: acc < A, so 2*acc < 2A fits in RW+1 bits and a single
  // conditional subtract brings it back into [0, A-1]. Since A is odd and
  // acc starts at 1, acc never becomes 0.
  // --------------------------------------------------------------------------
  logic [RW:0]   w_dbl;
  logic          w_ge;
  logic [RW-1:0] w_acc_next;

  assign w_dbl      = {r_acc, 1'b0};
  assign w_ge       = (w_dbl >= c_a_ext);
  assign w_acc_next = RW'(w_ge ? (w_dbl - c_a_ext) : w_dbl);

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sign    <= 1'b0;
      r_bad     <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_out_r   <= '0;
      r_out_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign  <= w_neg;
            r_bad   <= w_illegal;
            r_acc   <= RW'(1);
            // An illegal request skips all doublings and resolves on the
            // next edge, giving the same one-edge latency as |l| = 1.
            r_cnt   <= w_illegal ? '0 : (w_mag - LW'(1));
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          if (r_cnt != '0) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - LW'(1);
          end else begin
            if (r_bad) begin
              r_out_r   <= '0;
              r_out_err <= 1'b1;
            end else begin
              // acc is never 0, so A - acc stays inside [1, A-1].
              r_out_r   <= r_sign ? (c_a - r_acc) : r_acc;
              r_out_err <= 1'b0;
            end
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // Result registers are left untouched so they hold after the
          // handshake; a new request can only be taken from IDLE.
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: straight decodes of registered state
  // --------------------------------------------------------------------------
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_r     = r_out_r;
  assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_sec_loc_remainder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sec_loc_remainder
// Description : Directed self-checking bench for sec_loc_remainder. Two
//               instances: default parameters (A=17619) and a small one
//               (A=19, RW=5, LW=5, MAXL=9). Expected remainders, error flags
//               and latencies are hand-computed constants.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sec_loc_remainder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  in_l = '0;
  logic        sel = 1'b0;      // 0: default instance, 1: small instance

  int checks   = 0;
  int failures = 0;

  // default instance
  logic        a_in_ready, a_out_valid, a_out_err, a_busy;
  logic [14:0] a_out_r;
  // small instance
  logic        b_in_ready, b_out_valid, b_out_err, b_busy;
  logic [4:0]  b_out_r;

  sec_loc_remainder u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel),
    .in_ready  (a_in_ready),
    .in_l      (in_l),
    .out_valid (a_out_valid),
    .out_ready (out_ready & ~sel),
    .out_r     (a_out_r),
    .out_err   (a_out_err),
    .busy      (a_busy)
  );

  sec_loc_remainder #(.A(19), .RW(5), .LW(5), .MAXL(9)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel),
    .in_ready  (b_in_ready),
    .in_l      (in_l[4:0]),
    .out_valid (b_out_valid),
    .out_ready (out_ready & sel),
    .out_r     (b_out_r),
    .out_err   (b_out_err),
    .busy      (b_busy)
  );

  // observation mux for the selected instance
  logic        o_in_ready, o_out_valid, o_out_err, o_busy;
  logic [14:0] o_out_r;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_err   = sel ? b_out_err   : a_out_err;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_out_r     = sel ? {10'd0, b_out_r} : a_out_r;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request: accept, count edges to out_valid, check result, optionally
  // stall the consumer for 'hold' cycles, then hand the result off.
  task automatic do_req(input int lval, input int exp_r, input int exp_err,
                        input int exp_lat, input int hold);
    int lat;
    string s;
    s = $sformatf("sel=%0d l=%0d", sel, lval);
    @(negedge clk);
    in_valid  = 1'b1;
    in_l      = 7'(lval);
    out_ready = 1'b0;
    chk({"in_ready_idle ", s}, int'(o_in_ready), 1);
    @(posedge clk);                     // accept edge
    @(negedge clk);
    in_l = ~7'(lval);                   // ignored: not sampled outside accept
    lat  = 0;
    while (!o_out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({"latency ", s}, lat, exp_lat);
    chk({"out_r ", s}, int'(o_out_r), exp_r);
    chk({"out_err ", s}, int'(o_out_err), exp_err);
    chk({"busy_done ", s}, int'(o_busy), 1);
    chk({"in_ready_done ", s}, int'(o_in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;                  // must not be taken while in DONE
      in_l     = 7'd5;
      @(posedge clk);
      @(negedge clk);
      chk({"hold_valid ", s}, int'(o_out_valid), 1);
      chk({"hold_r ", s}, int'(o_out_r), exp_r);
      chk({"hold_ready ", s}, int'(o_in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);                     // handshake edge
    @(negedge clk);
    out_ready = 1'b0;
    chk({"idle_ready ", s}, int'(o_in_ready), 1);
    chk({"idle_valid ", s}, int'(o_out_valid), 0);
    chk({"idle_busy ", s}, int'(o_busy), 0);
    chk({"idle_hold_r ", s}, int'(o_out_r), exp_r);
  endtask

  initial begin : main
    int seen;
    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst a_out_valid", int'(a_out_valid), 0);
    chk("rst a_out_r", int'(a_out_r), 0);
    chk("rst a_out_err", int'(a_out_err), 0);
    chk("rst a_busy", int'(a_busy), 0);
    chk("rst a_in_ready", int'(a_in_ready), 1);
    chk("rst b_out_valid", int'(b_out_valid), 0);
    chk("rst b_in_ready", int'(b_in_ready), 1);
    rst = 1'b0;

    // ---------------- default instance ----------------
    sel = 1'b0;
    do_req(  1,     1, 0,  1, 0);
    do_req( -1, 17618, 0,  1, 0);
    do_req( 16, 15149, 0, 16, 0);
    do_req(-16,  2470, 0, 16, 0);
    do_req( 43, 12034, 0, 43, 0);
    do_req(-43,  5585, 0, 43, 0);
    do_req(  0,     0, 1,  1, 0);
    do_req( 44,     0, 1,  1, 0);
    do_req(-64,     0, 1,  1, 0);
    do_req( 22,   491, 0, 22, 5);

    // ---------------- reset during CALC ----------------
    @(negedge clk);
    in_valid = 1'b1;
    in_l     = 7'd30;
    @(posedge clk);                     // accept
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midcalc busy", int'(a_busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst in_ready", int'(a_in_ready), 1);
    chk("postrst out_valid", int'(a_out_valid), 0);
    chk("postrst out_r", int'(a_out_r), 0);
    chk("postrst out_err", int'(a_out_err), 0);
    chk("postrst busy", int'(a_busy), 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    chk("postrst no_valid", seen, 0);
    do_req(-30, 15256, 0, 30, 0);

    // ---------------- small instance ----------------
    sel = 1'b1;
    do_req(  9,  9, 0, 9, 0);
    do_req( -9, 10, 0, 9, 0);
    do_req( 10,  0, 1, 1, 0);
    do_req(-16,  0, 1, 1, 0);
    do_req(  3,  4, 0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
